// File: rtl/taiga_types.sv
// Shared types for the RV32I shift execution unit: op decode, stage-1 register
// and writeback FIFO entry.
package taiga_types;

    localparam int SHIFT_XLEN = 32;
    localparam int SHIFT_ID_W = 3;

    typedef enum logic [1:0] {SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ILLEGAL} shift_op_t;

    typedef struct packed {
        logic [SHIFT_XLEN-1:0] data;
        logic [4:0]            shamt;
        logic                  lshift;
        logic                  arith;
        logic [SHIFT_ID_W-1:0] id;
        logic [4:0]            rd;
        logic                  illegal;
    } shift_s1_t;

    typedef struct packed {
        logic [SHIFT_XLEN-1:0] data;
        logic [SHIFT_ID_W-1:0] id;
        logic [4:0]            rd;
        logic                  illegal;
    } shift_wb_t;

    function automatic shift_op_t decode_shift_op(input logic [2:0] fn3, input logic fn7_b5);
        case (fn3)
            3'b001:  return SHIFT_SLL;
            3'b101:  return fn7_b5 ? SHIFT_SRA : SHIFT_SRL;
            default: return SHIFT_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/barrel_shifter.sv
// 32-bit barrel shifter: left shifts are done by bit-reversing around a
// single right shifter whose fill bit is `arith`.
module barrel_shifter (
    input  logic [31:0] shifter_input,
    input  logic [4:0]  shift_amount,
    input  logic        arith,
    input  logic        lshift,
    output logic [31:0] shifted_result
);
    logic [31:0]        rev_in;
    logic [31:0]        right;
    logic signed [32:0] ext;

    always_comb begin
        for (int i = 0; i < 32; i++) rev_in[i] = shifter_input[31-i];
        ext   = $signed({arith, lshift ? rev_in : shifter_input}) >>> shift_amount;
        right = ext[31:0];
        shifted_result = right;
        if (lshift)
            for (int i = 0; i < 32; i++) shifted_result[i] = right[31-i];
    end
endmodule

// File: rtl/shift_unit_fifo.sv
// Small circular FIFO with flush; caller guarantees push only when space
// exists at the time the producer committed to the entry.
module shift_unit_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 3,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  T              din,
    input  logic          pop,
    output T              head,
    output logic          valid,
    output logic [CW-1:0] count
);
    T              mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          pop_eff;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid   = (count != '0);
    assign pop_eff = pop & valid;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)    wr_ptr <= wrap_inc(wr_ptr);
            if (pop_eff) rd_ptr <= wrap_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop_eff);
        end
    end

    // Storage needs no reset: entries are only observed while count covers them.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/shift_unit.sv
// RV32I shift execution unit: registered decode stage feeding barrel_shifter,
// results buffered in an output FIFO drained by the writeback handshake.
module shift_unit
    import taiga_types::*;
#(
    parameter int XLEN      = SHIFT_XLEN,
    parameter int ID_W      = SHIFT_ID_W,
    parameter int OUT_DEPTH = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [ID_W-1:0] issue_id,
    input  logic [4:0]      issue_rd,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      imm_shamt,
    input  logic            use_imm,
    input  logic [2:0]      fn3,
    input  logic            fn7_b5,
    output logic            wb_valid,
    input  logic            wb_ack,
    output logic [ID_W-1:0] wb_id,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_illegal
);
    localparam int CW = $clog2(OUT_DEPTH + 1);

    shift_op_t     op;
    shift_s1_t     s1, s1_next;
    logic          s1_valid;
    logic          accept;
    logic [31:0]   shifted_result;
    shift_wb_t     wb_in, head;
    logic          fifo_valid;
    logic [CW-1:0] fifo_count;
    logic          rs2_unused;

    assign rs2_unused = ^rs2[XLEN-1:5];

    // Occupancy counts the op in S1 so its FIFO slot is reserved at issue.
    assign issue_ready = (int'(fifo_count) + int'(s1_valid)) < OUT_DEPTH;
    assign accept      = issue_valid & issue_ready & ~flush;

    always_comb begin
        op              = decode_shift_op(fn3, fn7_b5);
        s1_next         = '0;
        s1_next.data    = rs1;
        s1_next.shamt   = use_imm ? imm_shamt : rs2[4:0];
        s1_next.lshift  = (op == SHIFT_SLL);
        s1_next.arith   = (op == SHIFT_SRA) & rs1[XLEN-1];
        s1_next.id      = issue_id;
        s1_next.rd      = issue_rd;
        s1_next.illegal = (op == SHIFT_ILLEGAL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) s1 <= s1_next;
        end
    end

    barrel_shifter u_shifter (
        .shifter_input  (s1.data),
        .shift_amount   (s1.shamt),
        .arith          (s1.arith),
        .lshift         (s1.lshift),
        .shifted_result (shifted_result)
    );

    always_comb begin
        wb_in.data    = s1.illegal ? '0 : shifted_result;
        wb_in.id      = s1.id;
        wb_in.rd      = s1.rd;
        wb_in.illegal = s1.illegal;
    end

    shift_unit_fifo #(.T(shift_wb_t), .DEPTH(OUT_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (s1_valid),
        .din   (wb_in),
        .pop   (wb_ack),
        .head  (head),
        .valid (fifo_valid),
        .count (fifo_count)
    );

    // Head fields read as zero when nothing is valid (reset, drained, flushed).
    assign wb_valid   = fifo_valid;
    assign wb_id      = fifo_valid ? head.id      : '0;
    assign wb_rd      = fifo_valid ? head.rd      : '0;
    assign wb_data    = fifo_valid ? head.data    : '0;
    assign wb_illegal = fifo_valid ? head.illegal : 1'b0;
endmodule

// File: tb/tb_shift_unit.sv
// Bench for shift_unit: directed and random ops against a queue-based model of
// accepted ops with their visibility cycle.
module tb_shift_unit;
    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic        issue_valid = 1'b0, issue_ready;
    logic [2:0]  issue_id = '0;
    logic [4:0]  issue_rd = '0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic [4:0]  imm_shamt = '0;
    logic        use_imm = 1'b0;
    logic [2:0]  fn3 = 3'b001;
    logic        fn7_b5 = 1'b0;
    logic        wb_valid, wb_ack = 1'b0;
    logic [2:0]  wb_id;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_illegal;

    typedef struct {
        logic [2:0]  id;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        ill;
        int          vis;
    } exp_t;

    exp_t q[$];
    int   ecount = 0;
    int   checks = 0, failures = 0;

    shift_unit dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_id(issue_id), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
        .imm_shamt(imm_shamt), .use_imm(use_imm), .fn3(fn3), .fn7_b5(fn7_b5),
        .wb_valid(wb_valid), .wb_ack(wb_ack), .wb_id(wb_id), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_illegal(wb_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [4:0] sh,
                                               input logic [2:0] f3, input logic f7);
        logic signed [31:0] sa;
        sa = a;
        if (f3 == 3'b001) return a << sh;
        if (f3 == 3'b101) return f7 ? 32'(sa >>> sh) : a >> sh;
        return 32'h0;
    endfunction

    // Check outputs against the model, advance the model by one edge, then clock.
    task automatic tick();
        bit   ev, rdy;
        exp_t e;
        ev  = (q.size() > 0) && (q[0].vis <= ecount);
        rdy = (q.size() < 3);
        chk("issue_ready", 32'(issue_ready), 32'(rdy));
        chk("wb_valid", 32'(wb_valid), 32'(ev));
        if (ev && wb_valid) begin
            chk("wb_id", 32'(wb_id), 32'(q[0].id));
            chk("wb_rd", 32'(wb_rd), 32'(q[0].rd));
            chk("wb_data", wb_data, q[0].data);
            chk("wb_illegal", 32'(wb_illegal), 32'(q[0].ill));
        end
        if (flush) q.delete();
        else begin
            if (ev && wb_ack) void'(q.pop_front());
            if (issue_valid && rdy) begin
                e.id   = issue_id;
                e.rd   = issue_rd;
                e.ill  = !(fn3 == 3'b001 || fn3 == 3'b101);
                e.data = ref_result(rs1, use_imm ? imm_shamt : rs2[4:0], fn3, fn7_b5);
                e.vis  = ecount + 2;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        ecount++;
    endtask

    task automatic set_op(input logic [2:0] id, input logic [4:0] rd, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] imm, input logic ui,
                          input logic [2:0] f3, input logic f7);
        issue_valid = 1'b1;
        issue_id = id; issue_rd = rd; rs1 = a; rs2 = b;
        imm_shamt = imm; use_imm = ui; fn3 = f3; fn7_b5 = f7;
    endtask

    // Issue a single op on an idle unit and check the result after two edges.
    task automatic run_one(input string tag, input logic [2:0] id, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] imm, input logic ui,
                           input logic [2:0] f3, input logic f7, input logic [31:0] exp);
        wb_ack = 1'b1;
        set_op(id, 5'(id) + 5'd3, a, b, imm, ui, f3, f7);
        tick();
        issue_valid = 1'b0;
        tick();
        chk({tag, "_valid"}, 32'(wb_valid), 32'd1);
        chk(tag, wb_data, exp);
        tick();
    endtask

    initial begin
        #2;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_id", 32'(wb_id), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_illegal", 32'(wb_illegal), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_one("sll31", 3'd1, 32'h0000_0001, 32'd31, 5'd0, 1'b0, 3'b001, 1'b0, 32'h8000_0000);
        run_one("sra_neg", 3'd2, 32'h8000_00F0, 32'd0, 5'd4, 1'b1, 3'b101, 1'b1, 32'hF800_000F);
        run_one("srl", 3'd3, 32'h8000_00F0, 32'd0, 5'd4, 1'b1, 3'b101, 1'b0, 32'h0800_000F);
        run_one("sra_pos", 3'd4, 32'h7000_0000, 32'd4, 5'd0, 1'b0, 3'b101, 1'b1, 32'h0700_0000);
        run_one("illegal", 3'd5, 32'h1234_5678, 32'd3, 5'd0, 1'b0, 3'b000, 1'b0, 32'h0);
        run_one("after_ill", 3'd6, 32'h0000_00FF, 32'd8, 5'd0, 1'b0, 3'b001, 1'b0, 32'h0000_FF00);
        run_one("sh0_sll", 3'd0, 32'hDEAD_BEEF, 32'd0, 5'd0, 1'b0, 3'b001, 1'b0, 32'hDEAD_BEEF);
        run_one("sh0_srl", 3'd1, 32'hDEAD_BEEF, 32'd0, 5'd0, 1'b1, 3'b101, 1'b0, 32'hDEAD_BEEF);
        run_one("sh0_sra", 3'd2, 32'hDEAD_BEEF, 32'd0, 5'd0, 1'b1, 3'b101, 1'b1, 32'hDEAD_BEEF);

        // Back-to-back ops under continuous ack.
        wb_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_op(3'(i), 5'(i), $urandom, $urandom, 5'($urandom), 1'b0, 3'b001, 1'b0);
            tick();
        end
        issue_valid = 1'b0;
        repeat (3) tick();

        // Stalled consumer: unit fills and holds its head.
        wb_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_op(3'(i), 5'(i + 10), $urandom, $urandom, 5'($urandom), 1'b1, 3'b101, 1'b1);
            tick();
        end
        chk("stall_ready", 32'(issue_ready), 32'd0);
        chk("stall_count", 32'(q.size()), 32'd3);
        issue_valid = 1'b0;
        wb_ack = 1'b1;
        repeat (4) tick();

        // Flush with two buffered, one in S1, and a simultaneous issue.
        wb_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_op(3'(i), 5'(i), $urandom, $urandom, 5'($urandom), 1'b0, 3'b101, 1'b0);
            tick();
        end
        set_op(3'd7, 5'd7, $urandom, $urandom, 5'd1, 1'b1, 3'b001, 1'b0);
        flush = 1'b1;
        wb_ack = 1'b1;
        tick();
        flush = 1'b0;
        issue_valid = 1'b0;
        chk("flush_wb_valid", 32'(wb_valid), 32'd0);
        chk("flush_ready", 32'(issue_ready), 32'd1);
        repeat (3) tick();

        // Random traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            int sel;
            sel = int'($urandom_range(0, 3));
            set_op(3'($urandom), 5'($urandom), $urandom, $urandom, 5'($urandom),
                   1'($urandom), sel == 0 ? 3'b001 : (sel == 3 ? 3'($urandom) : 3'b101),
                   1'($urandom));
            issue_valid = ($urandom_range(0, 3) != 0);
            wb_ack = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 39) == 0);
            tick();
        end
        flush = 1'b0;

        // Asynchronous reset mid-stream.
        wb_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_op(3'(i + 1), 5'(i + 1), 32'hFFFF_0000, 32'd4, 5'd0, 1'b0, 3'b001, 1'b0);
            tick();
        end
        issue_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wb_valid", 32'(wb_valid), 32'd0);
        chk("arst_wb_data", wb_data, 32'd0);
        chk("arst_wb_id", 32'(wb_id), 32'd0);
        chk("arst_wb_rd", 32'(wb_rd), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        ecount++;
        wb_ack = 1'b1;
        run_one("post_rst", 3'd3, 32'h0000_0010, 32'd0, 5'd2, 1'b1, 3'b101, 1'b0, 32'h0000_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
